// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between instruction fetch and data access
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              iwait,
   output logic              dwait,
   output logic [DATA_W-1:0] iload,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err,
   output logic              timeout
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR = 2'd3;
   typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;
   state_t state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] to_q, to_d;
   logic err_q, err_d, timeout_q, timeout_d;
   logic dreq, greq;
   assign dreq = dREN | dWEN;
   assign greq = (state_q == IGRANT && iREN) || (state_q == DGRANT && dreq);
   assign iload = ramload;
   assign dload = ramload;
   assign err = err_q;
   assign timeout = timeout_q;
   // arbitration, grant outputs, completion/abort/error/timeout handling
   always_comb begin
      state_d = state_q;
      starve_d = starve_q;
      to_d = '0;
      err_d = 1'b0;
      timeout_d = 1'b0;
      ramREN = 1'b0;
      ramWEN = 1'b0;
      ramaddr = '0;
      ramstore = '0;
      iwait = 1'b1;
      dwait = 1'b1;
      if (state_q == IGRANT) begin
         ramREN = iREN;
         ramaddr = iaddr;
      end
      if (state_q == DGRANT) begin
         ramWEN = dWEN;
         ramREN = dREN & ~dWEN;
         ramaddr = daddr;
         ramstore = dstore;
      end
      if (state_q == IDLE) begin
         if (dreq && !(iREN && starve_q == STARVE_MAX)) state_d = DGRANT;
         else if (iREN) state_d = IGRANT;
         else starve_d = '0;
      end else if (!greq) begin
         state_d = IDLE;
      end else if (ramstate == RAM_ACCESS) begin
         state_d = IDLE;
         iwait = state_q != IGRANT;
         dwait = state_q != DGRANT;
         starve_d = state_q == IGRANT ? '0 : (iREN && starve_q != STARVE_MAX) ? starve_q + 1'b1 : starve_q;
      end else if (ramstate == RAM_ERROR) begin
         state_d = IDLE;
         err_d = 1'b1;
      end else if (to_q == TO_LAST) begin
         state_d = IDLE;
         timeout_d = 1'b1;
      end else begin
         to_d = to_q + 1'b1;
      end
   end
   // state and counter registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         starve_q <= '0;
         to_q <= '0;
         err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         starve_q <= starve_d;
         to_q <= to_d;
         err_q <= err_d;
         timeout_q <= timeout_d;
      end
   end
endmodule
